// File: rtl/updown_step_arbiter_if.sv
// Bus between the two requesters/counter side and updown_step_arbiter.
// Handshake: a requester raises its req bit (with dir/steps stable at the
// sampling edge) and holds it while granted; the arbiter answers with a
// one-cycle done pulse carrying done_id, and the requester drops req in
// that done cycle. A req still high when the arbiter returns to IDLE is a
// new request. The state field mirrors the arbiter FSM for debug.
interface updown_step_arbiter_if;
    logic [1:0] req;
    logic [1:0] dir;
    logic [2:0] steps_a;
    logic [2:0] steps_b;
    logic [2:0] cnt_val;
    logic [1:0] gnt;
    logic       busy;
    logic       cnt_up;
    logic       cnt_down;
    logic       done;
    logic       done_id;
    logic       sat;
    logic [1:0] state;

    modport master (
        output req, dir, steps_a, steps_b, cnt_val,
        input  gnt, busy, cnt_up, cnt_down, done, done_id, sat, state
    );

    modport slave (
        input  req, dir, steps_a, steps_b, cnt_val,
        output gnt, busy, cnt_up, cnt_down, done, done_id, sat, state
    );
endinterface

// File: rtl/updown_step_arbiter.sv
// Round-robin arbiter sharing one 3-bit up/down counter between two
// requesters (A = index 0, B = index 1). The winner's burst of 0..7 steps
// is played out as one-cycle up/down strobes separated by STEP_GAP idle
// cycles. Optional macro UPDOWN_STEP_SAT_EN aborts a burst instead of
// letting the counter wrap, flagging sat together with done.
module updown_step_arbiter #(
    parameter int STEP_GAP   = 0,
    parameter int FIRST_PRIO = 0
) (
    input logic                  clk,
    input logic                  rst,
    updown_step_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bit         HAS_GAP   = (STEP_GAP > 0);
    localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(STEP_GAP - 1) : 4'd0;
    // last_q holds the previous winner; the opposite index wins a tie,
    // so it starts as the complement of FIRST_PRIO.
    localparam logic       LAST_INIT = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t     state_q;
    state_t     state_d;
    logic       id_q;
    logic       dir_q;
    logic       sat_q;
    logic       last_q;
    logic [2:0] rem_q;
    logic [3:0] gap_q;

    logic       win;
    logic [2:0] win_steps;
    logic       sat_hit;

    logic       up_strobe;
    logic       down_strobe;
    logic       done_pulse;
    logic       busy_flag;
    logic       sat_flag;
    logic [1:0] grant;

    // Winner selection for the IDLE sampling edge: a lone requester wins,
    // a tie goes to whoever did not win last.
    always_comb begin
        win = 1'b0;
        if (bus.req == 2'b10) begin
            win = 1'b1;
        end else if (bus.req == 2'b11) begin
            win = ~last_q;
        end
        win_steps = win ? bus.steps_b : bus.steps_a;
    end

`ifdef UPDOWN_STEP_SAT_EN
    // A step that would wrap the counter ends the burst instead.
    assign sat_hit = dir_q ? (bus.cnt_val == 3'd7) : (bus.cnt_val == 3'd0);
`else
    // Wrapping is allowed; the counter value is not needed.
    logic unused_cnt_val;
    assign unused_cnt_val = ^bus.cnt_val;
    assign sat_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs, decoded from registered state and latched fields.
    always_comb begin
        state_d     = state_q;
        up_strobe   = 1'b0;
        down_strobe = 1'b0;
        done_pulse  = 1'b0;
        busy_flag   = 1'b1;
        sat_flag    = 1'b0;
        grant       = id_q ? 2'b10 : 2'b01;
        case (state_q)
            IDLE: begin
                busy_flag = 1'b0;
                grant     = 2'b00;
                if (bus.req != 2'b00) begin
                    state_d = (win_steps == 3'd0) ? DONE : STEP;
                end
            end
            STEP: begin
                up_strobe   = dir_q & ~sat_hit;
                down_strobe = ~dir_q & ~sat_hit;
                if (sat_hit || rem_q == 3'd1) begin
                    state_d = DONE;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = STEP;
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                sat_flag   = sat_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched burst fields, step/gap counters and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q   <= 1'b0;
            dir_q  <= 1'b0;
            sat_q  <= 1'b0;
            last_q <= LAST_INIT;
            rem_q  <= 3'd0;
            gap_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        id_q  <= win;
                        dir_q <= bus.dir[win];
                        rem_q <= win_steps;
                        sat_q <= 1'b0;
                    end
                end
                STEP: begin
                    gap_q <= GAP_LOAD;
                    if (sat_hit) begin
                        sat_q <= 1'b1;
                        rem_q <= 3'd0;
                    end else begin
                        rem_q <= rem_q - 3'd1;
                    end
                end
                GAP: begin
                    if (gap_q != 4'd0) begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                DONE: begin
                    last_q <= id_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.gnt      = grant;
    assign bus.busy     = busy_flag;
    assign bus.cnt_up   = up_strobe;
    assign bus.cnt_down = down_strobe;
    assign bus.done     = done_pulse;
    assign bus.done_id  = id_q & done_pulse;
    assign bus.sat      = sat_flag;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_updown_step_arbiter.sv
// Bench for updown_step_arbiter: two instances (STEP_GAP 0 / FIRST_PRIO 0
// and STEP_GAP 2 / FIRST_PRIO 1), each with its own 3-bit counter, driver,
// expected queue and monitor. Directed bursts first, then random ones.
module tb_updown_step_arbiter;

    typedef struct {
        logic       id;
        logic       up;
        int         nstr;
        int         k;
        int         done_cyc;
        logic       sat;
        logic [2:0] fin;
    } exp_t;

    localparam int ND    = 11;
    localparam int NRAND = 40;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   drv_count = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int u, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s u%0d cyc=%0d got=%0d expected=%0d", nm, u, cyc, act, want);
        end
    endtask

    // Reference: burst outcome from the rules, using the counter value
    // at the sampling cycle k.
    function automatic exp_t predict(input logic id, input logic up, input int n,
                                     input int k, input logic [2:0] start, input int g);
        exp_t e;
        int   m;
        m     = n;
        e.sat = 1'b0;
`ifdef UPDOWN_STEP_SAT_EN
        begin
            int room;
            room = up ? 7 - int'(start) : int'(start);
            if (n > room) begin
                m     = room;
                e.sat = 1'b1;
            end
        end
`endif
        e.id   = id;
        e.up   = up;
        e.nstr = m;
        e.k    = k;
        if (n == 0) e.done_cyc = k + 1;
        else if (e.sat) e.done_cyc = k + 2 + m * (g + 1);
        else e.done_cyc = k + 2 + (m - 1) * (g + 1);
        e.fin = up ? start + 3'(m) : start - 3'(m);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int G  = g * 2;
        localparam int FP = g;

        logic       rst;
        logic [2:0] cnt = 3'd0;
        logic [2:0] model_cnt = 3'd0;
        logic       quiet = 1'b1;
        logic       last_w;
        exp_t       exp_q[$];

        updown_step_arbiter_if bus ();

        updown_step_arbiter #(.STEP_GAP(G), .FIRST_PRIO(FP)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        // The shared counter the arbiter drives.
        assign bus.cnt_val = cnt;
        always @(posedge clk) begin
            if (bus.cnt_up) cnt <= cnt + 3'd1;
            else if (bus.cnt_down) cnt <= cnt - 3'd1;
        end

        // Monitor: checks strobes against the queue head, pops on done.
        initial begin : mon
            int   str_seen;
            int   busy_cnt;
            exp_t e;
            str_seen = 0;
            busy_cnt = 0;
            forever begin
                @(negedge clk);
                if (quiet || !rst) begin
                    str_seen = 0;
                    busy_cnt = 0;
                end else begin
                    if (bus.cnt_up || bus.cnt_down) begin
                        chk("strobe_excl", g, int'(bus.cnt_up & bus.cnt_down), 0);
                        chk("strobe_expected", g, int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q[0];
                            chk("strobe_cycle", g, cyc, e.k + 1 + str_seen * (G + 1));
                            chk("strobe_dir", g, int'(bus.cnt_up), int'(e.up));
                            chk("strobe_gnt", g, int'(bus.gnt), e.id ? 2 : 1);
                        end
                        str_seen++;
                    end
                    if (bus.busy) busy_cnt++;
                    else chk("idle_outputs", g,
                             int'({bus.gnt, bus.done, bus.cnt_up, bus.cnt_down}), 0);
                    if (bus.done) begin
                        chk("done_expected", g, int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("done_id", g, int'(bus.done_id), int'(e.id));
                            chk("sat", g, int'(bus.sat), int'(e.sat));
                            chk("strobe_count", g, str_seen, e.nstr);
                            chk("done_cycle", g, cyc, e.done_cyc);
                            chk("busy_cycles", g, busy_cnt, e.done_cyc - e.k);
                            chk("done_gnt", g, int'(bus.gnt), e.id ? 2 : 1);
                            chk("counter", g, int'(cnt), int'(e.fin));
                        end
                        str_seen = 0;
                        busy_cnt = 0;
                    end
                end
            end
        end

        // Driver: issues one request at a time and pushes its expectation.
        initial begin : drv
            logic [1:0] pat;
            logic [1:0] dv;
            logic [2:0] sa;
            logic [2:0] sb;
            logic       w;
            logic       up;
            int         n;
            int         kind;
            bit         got;
            exp_t       e;
            rst         = 1'b0;
            bus.req     = 2'b00;
            bus.dir     = 2'b00;
            bus.steps_a = 3'd0;
            bus.steps_b = 3'd0;
            last_w      = (FP == 0);
            repeat (2) @(negedge clk);
            chk("reset_outputs", g, int'({bus.gnt, bus.busy, bus.cnt_up, bus.cnt_down,
                                          bus.done, bus.done_id, bus.sat}), 0);
            chk("reset_state", g, int'(bus.state), 0);
            rst   = 1'b1;
            quiet = 1'b0;
            for (int t = 0; t < ND + NRAND; t++) begin
                @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                kind = 0;
                pat  = 2'($urandom_range(1, 3));
                dv   = 2'($urandom);
                sa   = 3'($urandom);
                sb   = 3'($urandom);
                case (t)
                    0: begin pat = 2'b01; dv = 2'b01; sa = 3'd3; sb = 3'd0; end
                    1, 2, 3, 4, 8: begin pat = 2'b11; dv = 2'b11; sa = 3'd1; sb = 3'd1; end
                    5: begin pat = 2'b10; dv = 2'b00; sa = 3'd0; sb = 3'd2; end
                    6: begin pat = 2'b01; dv = 2'b00; sa = 3'd0; sb = 3'd0; end
                    7: begin pat = 2'b01; dv = 2'b01; sa = 3'd5; sb = 3'd0; kind = 1; end
                    9: begin
                        pat = 2'b01;
                        sb  = 3'd0;
                        if (model_cnt <= 3'd6) begin dv = 2'b01; sa = 3'd6 - model_cnt; end
                        else begin dv = 2'b00; sa = 3'd1; end
                    end
                    10: begin pat = 2'b01; dv = 2'b01; sa = 3'd4; sb = 3'd0; end
                    default: begin end
                endcase
                w  = (pat == 2'b01) ? 1'b0 : (pat == 2'b10) ? 1'b1 : ~last_w;
                n  = w ? int'(sb) : int'(sa);
                up = dv[w];
                if (kind == 1) quiet = 1'b1;
                bus.dir     = dv;
                bus.steps_a = sa;
                bus.steps_b = sb;
                bus.req     = pat;
                if (kind == 1) begin
                    // Reset one cycle after the second strobe of a 5-step up burst.
                    repeat (3 + G) @(negedge clk);
                    rst = 1'b0;
                    #1;
                    chk("midreset_outputs", g, int'({bus.gnt, bus.busy, bus.cnt_up,
                                                     bus.cnt_down, bus.done, bus.sat}), 0);
                    chk("midreset_state", g, int'(bus.state), 0);
                    model_cnt = model_cnt + 3'd2;
                    bus.req   = 2'b00;
                    @(negedge clk);
                    rst    = 1'b1;
                    quiet  = 1'b0;
                    last_w = (FP == 0);
                end else begin
                    e = predict(w, up, n, cyc, model_cnt, G);
                    exp_q.push_back(e);
                    model_cnt = e.fin;
                    got = 0;
                    for (int i = 0; i < 100 && !got; i++) begin
                        @(negedge clk);
                        if (i == 0) begin
                            // Changing fields while granted must not matter.
                            bus.dir     = 2'($urandom);
                            bus.steps_a = 3'($urandom);
                            bus.steps_b = 3'($urandom);
                        end
                        if (bus.done) got = 1;
                    end
                    bus.req = 2'b00;
                    chk("done_seen", g, int'(got), 1);
                    if (!got) exp_q.delete();
                    else last_w = w;
                end
            end
            repeat (3) @(negedge clk);
            chk("queue_empty", g, exp_q.size(), 0);
            drv_count++;
        end
    end

    // Final report.
    initial begin
        wait (drv_count == 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog.
    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog cyc=%0d got=timeout expected=completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
